// File: rtl/activation_pkg.sv
// Shared types and Q-format defaults for the activation stage.
package activation_pkg;

    typedef enum logic [1:0] {
        ACT_STEP  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_HSIG  = 2'd3
    } act_mode_e;

    // Default Q15.16 signed word.
    localparam int unsigned DEF_SIGN = 1;
    localparam int unsigned DEF_Q_M  = 15;
    localparam int unsigned DEF_Q_N  = 16;

endpackage

// File: rtl/activation_lane.sv
// Combinational activation of one signed fixed-point lane.
module activation_lane
    import activation_pkg::*;
#(
    parameter int unsigned SIGN       = DEF_SIGN,
    parameter int unsigned Q_M        = DEF_Q_M,
    parameter int unsigned Q_N        = DEF_Q_N,
    parameter int unsigned LEAK_SHIFT = 3,
    localparam int unsigned W         = SIGN + Q_M + Q_N
) (
    input  act_mode_e      mode,
    input  logic [W-1:0]   x,
    output logic [W-1:0]   y,
    output logic           positive
);

    localparam logic signed [W-1:0] ONE  = W'(1) << Q_N;
    localparam logic signed [W-1:0] HALF = W'(1) << (Q_N - 1);

    logic signed [W-1:0] xs;
    logic signed [W-1:0] leak;
    logic signed [W-1:0] hsig;

    // Signed intermediates kept in their own statements so >>> stays arithmetic.
    always_comb begin
        xs   = x;
        leak = xs >>> LEAK_SHIFT;
        hsig = (xs >>> 2) + HALF;
    end

    // Mode select and clamping.
    always_comb begin
        y = '0;
        case (mode)
            ACT_STEP:  y = (!xs[W-1] && (xs != '0)) ? ONE : '0;
            ACT_RELU:  y = xs[W-1] ? '0 : x;
            ACT_LEAKY: y = xs[W-1] ? leak : x;
            ACT_HSIG: begin
                if (hsig[W-1]) begin
                    y = '0;
                end else if (hsig > ONE) begin
                    y = ONE;
                end else begin
                    y = hsig;
                end
            end
            default:   y = '0;
        endcase
        positive = !y[W-1] && (y != '0);
    end

endmodule

// File: rtl/activation_unit.sv
// Multi-lane activation stage: 2-stage valid/ready pipeline plus positive-lane counter.
module activation_unit
    import activation_pkg::*;
#(
    parameter int unsigned SIGN       = DEF_SIGN,
    parameter int unsigned Q_M        = DEF_Q_M,
    parameter int unsigned Q_N        = DEF_Q_N,
    parameter int unsigned LANES      = 4,
    parameter int unsigned LEAK_SHIFT = 3,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned W         = SIGN + Q_M + Q_N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic [LANES*W-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_mode,
    output logic [LANES*W-1:0]   out_data,
    input  logic                 cnt_clear,
    output logic [CNT_W-1:0]     active_count
);

    localparam int unsigned PW = $clog2(LANES + 1);
    localparam int unsigned SW = CNT_W + PW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 s1_valid_q, s2_valid_q;
    act_mode_e            s1_mode_q, s2_mode_q;
    logic [LANES*W-1:0]   s1_data_q, s2_data_q;
    logic [LANES-1:0]     s2_pos_q;
    logic [LANES*W-1:0]   lane_y;
    logic [LANES-1:0]     lane_pos;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PW-1:0]        pop;
    logic [SW-1:0]        sum;
    logic                 s1_adv, s2_adv, out_xfer;

    // Each stage advances when empty or when its consumer is taking the current word.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv && !rst;
        out_xfer = s2_valid_q && out_ready;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        activation_lane #(
            .SIGN       (SIGN),
            .Q_M        (Q_M),
            .Q_N        (Q_N),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .mode     (s1_mode_q),
            .x        (s1_data_q[i*W +: W]),
            .y        (lane_y[i*W +: W]),
            .positive (lane_pos[i])
        );
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= ACT_STEP;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_mode_q  <= ACT_STEP;
            s2_data_q  <= '0;
            s2_pos_q   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_mode_q <= act_mode_e'(in_mode);
                    s1_data_q <= in_data;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_mode_q <= s1_mode_q;
                    s2_data_q <= lane_y;
                    s2_pos_q  <= lane_pos;
                end
            end
        end
    end

    // Saturating add of the popcount of positive lanes; clear has priority.
    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + PW'(s2_pos_q[i]);
        end
        sum     = SW'(count_q) + SW'(pop);
        count_d = count_q;
        if (cnt_clear) begin
            count_d = '0;
        end else if (out_xfer) begin
            count_d = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Stage 2 drives the outputs directly.
    always_comb begin
        out_valid    = s2_valid_q;
        out_mode     = s2_mode_q;
        out_data     = s2_data_q;
        active_count = count_q;
    end

endmodule

// File: tb/tb_activation_unit.sv
// Scoreboard bench for activation_unit: driver pushes expectations, monitor checks outputs.
module tb_activation_unit;

    localparam int LANES = 4;
    localparam int W     = 32;
    localparam int LW    = LANES * W;
    localparam int CMAX  = 15;

    typedef struct {
        logic [1:0]    mode;
        logic [LW-1:0] data;
        int            cyc;
        bit            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic [LW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_mode;
    logic [LW-1:0] out_data;
    logic          cnt_clear;
    logic [3:0]    active_count;

    exp_t          sb[$];
    logic [LW-1:0] drv_exp;
    bit            drv_lat;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            model_cnt = 0;
    int            bp_cnt = 0;
    bit            def_ready = 1'b1;
    bit            rnd_ready = 1'b0;
    bit            saw_stall = 1'b0;
    bit            hold_v = 1'b0;
    logic [LW-1:0] hold_d;
    logic [1:0]    hold_m;

    activation_unit #(
        .SIGN       (1),
        .Q_M        (15),
        .Q_N        (16),
        .LANES      (LANES),
        .LEAK_SHIFT (3),
        .CNT_W      (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mode     (out_mode),
        .out_data     (out_data),
        .cnt_clear    (cnt_clear),
        .active_count (active_count)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input bit ok, input string nm, input logic [LW-1:0] act,
                       input logic [LW-1:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Reference model: plain integer arithmetic on real values scaled by 2^16.
    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if (q * b != a && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [W-1:0] ref_lane(input logic [1:0] m, input logic [W-1:0] x);
        longint v, y;
        v = longint'($signed(x));
        case (m)
            2'd0: y = (v > 0) ? 65536 : 0;
            2'd1: y = (v < 0) ? 0 : v;
            2'd2: y = (v < 0) ? floor_div(v, 8) : v;
            default: begin
                y = floor_div(v, 4) + 32768;
                if (y < 0) y = 0;
                if (y > 65536) y = 65536;
            end
        endcase
        return y[W-1:0];
    endfunction

    function automatic logic [LW-1:0] ref_vec(input logic [1:0] m, input logic [LW-1:0] d);
        logic [LW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*W +: W] = ref_lane(m, d[i*W +: W]);
        return r;
    endfunction

    function automatic int npos(input logic [LW-1:0] d);
        int n = 0;
        for (int i = 0; i < LANES; i++) begin
            if ($signed(d[i*W +: W]) > 0) n++;
        end
        return n;
    endfunction

    function automatic logic [W-1:0] rnd_lane();
        case ($urandom_range(0, 3))
            0: return W'($urandom());
            1: return W'(int'($urandom_range(0, 32'h60000)) - 32'h30000);
            2: return '0;
            default: begin
                case ($urandom_range(0, 3))
                    0: return 32'h7FFF_FFFF;
                    1: return 32'h8000_0000;
                    2: return 32'h0001_0000;
                    default: return 32'hFFFF_FFFF;
                endcase
            end
        endcase
    endfunction

    // out_ready driver, applied #2 after the edge so the main sequence can set its controls at #1.
    initial forever begin
        @(posedge clk);
        #2;
        if (bp_cnt > 0) begin
            out_ready = 1'b0;
            bp_cnt--;
        end else if (rnd_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = def_ready;
        end
    end

    // Monitor: samples mid-cycle, checks handshake, outputs and counter against the model.
    initial begin
        exp_t e;
        bit   xfer;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk(in_ready === (!rst && !(sb.size() == 2 && !out_ready)), "in_ready",
                LW'(in_ready), LW'(!rst && !(sb.size() == 2 && !out_ready)));
            chk(active_count === 4'(model_cnt), "active_count", LW'(active_count),
                LW'(model_cnt));
            if (rst) begin
                sb.delete();
                model_cnt = 0;
                hold_v = 1'b0;
            end else begin
                if (hold_v && out_valid) begin
                    chk(out_data === hold_d, "stall_data", out_data, hold_d);
                    chk(out_mode === hold_m, "stall_mode", LW'(out_mode), LW'(hold_m));
                end
                hold_v = out_valid && !out_ready;
                hold_d = out_data;
                hold_m = out_mode;
                if (in_valid && !in_ready) saw_stall = 1'b1;
                xfer = out_valid && out_ready;
                if (xfer) begin
                    if (sb.size() == 0) begin
                        chk(1'b0, "unexpected_output", out_data, '0);
                    end else begin
                        e = sb.pop_front();
                        chk(out_data === e.data, "out_data", out_data, e.data);
                        chk(out_mode === e.mode, "out_mode", LW'(out_mode), LW'(e.mode));
                        if (e.lat) chk(cyc - e.cyc == 2, "latency", LW'(cyc - e.cyc), LW'(2));
                        if (!cnt_clear) begin
                            model_cnt = model_cnt + npos(e.data);
                            if (model_cnt > CMAX) model_cnt = CMAX;
                        end
                    end
                end
                if (cnt_clear) model_cnt = 0;
                if (in_valid && in_ready) begin
                    e.mode = in_mode;
                    e.data = drv_exp;
                    e.cyc  = cyc;
                    e.lat  = drv_lat;
                    sb.push_back(e);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input logic [1:0] m, input logic [LW-1:0] d, input logic [LW-1:0] ex);
        int n = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        drv_exp  = ex;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk(1'b0, "send_timeout", LW'(n), LW'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_dir(input logic [1:0] m, input logic [LW-1:0] d, input logic [LW-1:0] ex);
        drv_lat = 1'b1;
        send(m, d, ex);
        drv_lat = 1'b0;
    endtask

    task automatic send_rnd(input logic [1:0] m);
        logic [LW-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*W +: W] = rnd_lane();
        send(m, d, ref_vec(m, d));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_mode = '0;
        in_data = '0;
        cnt_clear = 1'b0;
        out_ready = 1'b1;
        drv_exp = '0;
        drv_lat = 1'b0;
        idle(2);
        chk(out_valid === 1'b0, "rst_out_valid", LW'(out_valid), '0);
        chk(out_data === '0, "rst_out_data", out_data, '0);
        chk(out_mode === 2'd0, "rst_out_mode", LW'(out_mode), '0);
        chk(active_count === 4'd0, "rst_count", LW'(active_count), '0);
        chk(in_ready === 1'b0, "rst_in_ready", LW'(in_ready), '0);
        rst = 1'b0;

        // Directed vectors, lane 0 in the low bits.
        send_dir(2'd0, {32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_0000, 32'h0000_0000},
                       {32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000});
        idle(3);
        chk(active_count === 4'd2, "step_count", LW'(active_count), LW'(2));
        send_dir(2'd1, {32'h0, 32'h0, 32'h0002_8000, 32'hFFFF_0000},
                       {32'h0, 32'h0, 32'h0002_8000, 32'h0000_0000});
        send_dir(2'd2, {32'h0, 32'h0, 32'h0002_8000, 32'hFFFF_0000},
                       {32'h0, 32'h0, 32'h0002_8000, 32'hFFFF_E000});
        send_dir(2'd3, {32'h0001_0000, 32'hFFFE_0000, 32'h0002_0000, 32'h0000_0000},
                       {32'h0000_C000, 32'h0000_0000, 32'h0001_0000, 32'h0000_8000});
        idle(4);

        // Backpressure mid-stream: 8 back-to-back transfers, out_ready low for 5 cycles.
        saw_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_rnd(2'(i % 4));
            if (i == 2) bp_cnt = 5;
        end
        idle(6);
        chk(saw_stall == 1'b1, "bp_in_ready_drop", LW'(saw_stall), LW'(1));
        chk(sb.size() == 0, "bp_drained", LW'(sb.size()), '0);

        // Counter saturation from zero.
        cnt_clear = 1'b1;
        idle(1);
        cnt_clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(2'd0, {4{32'h0001_0000}}, {4{32'h0001_0000}});
        end
        idle(4);
        chk(active_count === 4'd15, "sat_count", LW'(active_count), LW'(15));

        // Clear coincident with an output transfer.
        def_ready = 1'b0;
        idle(1);
        send(2'd0, {4{32'h0000_0100}}, {4{32'h0001_0000}});
        idle(2);
        def_ready = 1'b1;
        cnt_clear = 1'b1;
        idle(1);
        cnt_clear = 1'b0;
        chk(active_count === 4'd0, "clear_wins", LW'(active_count), '0);

        // Randomised traffic with random backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send_rnd(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        rnd_ready = 1'b0;
        idle(20);

        // Reset with two transfers in flight.
        def_ready = 1'b0;
        idle(1);
        send_rnd(2'd1);
        send_rnd(2'd3);
        rst = 1'b1;
        #2;
        chk(in_ready === 1'b0, "rst_mid_in_ready", LW'(in_ready), '0);
        @(posedge clk);
        #1;
        chk(out_valid === 1'b0, "rst_mid_valid", LW'(out_valid), '0);
        chk(out_data === '0, "rst_mid_data", out_data, '0);
        chk(active_count === 4'd0, "rst_mid_count", LW'(active_count), '0);
        rst = 1'b0;
        def_ready = 1'b1;
        idle(6);
        send_dir(2'd2, {32'hFFFF_FFF8, 32'h8000_0000, 32'h0000_0010, 32'hFFFF_FFFF},
                       {32'hFFFF_FFFF, 32'hF000_0000, 32'h0000_0010, 32'hFFFF_FFFF});
        idle(4);
        chk(sb.size() == 0, "final_drained", LW'(sb.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/activation_unit.md
# activation_unit

Streaming, multi-lane, multi-mode activation stage for the perceptron/neural-network datapath. It sits between the weighted-summation stage and the next layer's input buffer. It accepts a vector of `LANES` signed fixed-point sums per transfer and applies a per-transfer selectable activation: step, ReLU, leaky ReLU, or hard sigmoid. Results pass through a 2-stage valid/ready pipeline, and the block keeps a saturating count of positive activations for layer-sparsity monitoring.

## Interface
- `SIGN`, 1, sign bit count; must be 1.
- `Q_M`, 15, integer bits; must be ≥1.
- `Q_N`, 16, fraction bits; must be ≥1. Word width `W = SIGN+Q_M+Q_N`.
- `LANES`, 4, parallel sums per transfer; ≥1.
- `LEAK_SHIFT`, 3, leaky-ReLU negative slope is 2^-LEAK_SHIFT; 1..W-1.
- `CNT_W`, 16, width of `active_count`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  input transfer valid.
- `in_ready`  out  1  input can be accepted.
- `in_mode`  in  2  activation mode, qualified by `in_valid`.
- `in_data`  in  LANES*W  sums; lane i at bits [i*W +: W], two's complement Q(Q_M).(Q_N).
- `out_valid`  out  1  output transfer valid.
- `out_ready`  in  1  downstream accepts.
- `out_mode`  out  2  mode echoed with the result.
- `out_data`  out  LANES*W  activations, same lane packing and format.
- `cnt_clear`  in  1  synchronous clear of `active_count`.
- `active_count`  out  CNT_W  saturating count of positive output lanes.

## Operation
- Constants: ONE = 1<<Q_N; HALF = 1<<(Q_N-1).
- The mode is applied independently to every lane of the transfer. x is the signed lane value.
  - ACT_STEP (0): x>0 → ONE; x≤0 (including 0) → 0.
  - ACT_RELU (1): x<0 → 0; otherwise x.
  - ACT_LEAKY (2): x<0 → x>>>LEAK_SHIFT (arithmetic, floor); otherwise x.
  - ACT_HSIG (3): y = (x>>>2) + HALF, clamped to [0, ONE]. Compute in W bits; overflow cannot occur because the shift shrinks magnitude.
- Pipeline:
  - S1 registers {valid, mode, raw data}.
  - Lane function sits between S1 and S2.
  - S2 registers {valid, mode, result}. S2 drives `out_*` directly.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv && !rst.
- Accept/transfer:
  - Input is accepted when in_valid && in_ready.
  - Output is transferred when out_valid && out_ready.
- `out_data`/`out_mode` stay stable while out_valid && !out_ready.
- Data is never dropped or duplicated. Full throughput is one transfer per cycle.
- Counter:
  - On each output transfer, add the number of lanes whose result is >0 (sign 0, nonzero).
  - Saturates at 2^CNT_W-1. Leaky negatives and zeros are not counted.
  - cnt_clear in the same cycle as a transfer: the clear wins, count becomes 0.
- Reset:
  - All valids go to 0. `out_data`, `out_mode` and `active_count` go to 0.
  - In-flight transfers are discarded, including when rst hits mid-stream.
  - in_ready is 0 during any cycle with rst high.

## Timing
- Latency: a transfer accepted in cycle t is presented with out_valid=1 in cycle t+2 when out_ready has been high.
- Pipeline holds at most 2 transfers.
- If out_ready is low with both stages full, in_ready goes low the same cycle. The path is combinational from out_ready.
- `in_ready` returns high the cycle out_ready rises.
- Reset asserted in cycle t: outputs show reset values in cycle t+1, and the first accept is possible in the first cycle rst is low.
- `active_count` updates the cycle after the output transfer.

## Structure
- `activation_pkg`:
  - `act_mode_e` enum, 2-bit: ACT_STEP=0, ACT_RELU=1, ACT_LEAKY=2, ACT_HSIG=3.
  - Shared Q-format defaults: SIGN, Q_M, Q_N.
- Sub-module `activation_lane`:
  - Purely combinational, one W-bit lane, parameters SIGN/Q_M/Q_N/LEAK_SHIFT, inputs mode and x.
  - Instantiated LANES times in a generate loop.
  - Also outputs a `positive` flag used by the counter popcount.

## Test plan
- Step, Q15.16, LANES=4, lanes {0x00000000, 0xFFFF0000, 0x00000001, 0x7FFFFFFF} → {0, 0, 0x00010000, 0x00010000} at cycle t+2; active_count=2.
- ReLU/leaky, lanes {0xFFFF0000 (−1.0), 0x00028000 (2.5)}:
  - ReLU → {0, 0x00028000}.
  - Leaky with LEAK_SHIFT=3 → {0xFFFFE000 (−0.125), 0x00028000}.
- Hard sigmoid, lanes {0, 0x00020000, 0xFFFE0000, 0x00010000} → {0x00008000, 0x00010000, 0, 0x0000C000}.
- Backpressure:
  - Stream 8 transfers in consecutive cycles with mixed modes.
  - Hold out_ready low for 5 cycles mid-stream: in_ready drops after 2 are in flight, out_data is stable, and all 8 results arrive in order with no loss.
- Counter: CNT_W=4.
  - Send step transfers with 4 positive lanes until the count saturates at 15.
  - Assert cnt_clear simultaneously with an output transfer: count reads 0.
- Reset mid-operation:
  - Assert rst for 1 cycle with 2 transfers in flight.
  - Next cycle out_valid=0, out_data=0, active_count=0, in_ready=0 while rst is high.
  - No stale transfer emerges afterward.
